// File: rtl/adc_sample_controller.sv
// Sample-rate sequencer and SPI-style read engine for an ADCS7476-class serial ADC.
// A single-clock period counter issues ticks; each tick runs one cs_n/sclk conversion frame.
module adc_sample_controller #(
    parameter int CLK_DIV     = 2268,
    parameter int SCLK_HALF   = 4,
    parameter int FRAME_BITS  = 16,
    parameter int DATA_W      = 12,
    parameter int QUIET       = 8,
    parameter int CHECK_LEGAL = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sdata,
    output logic              cs_n,
    output logic              sclk,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int PER_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PH_W  = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam int Q_W   = (QUIET > 1) ? $clog2(QUIET) : 1;

    localparam logic [PER_W-1:0] PER_LAST = PER_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SCLK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS);
    localparam logic [Q_W-1:0]   Q_LAST   = Q_W'(QUIET - 1);

    localparam bit LEGAL = (CLK_DIV > FRAME_BITS * 2 * SCLK_HALF + SCLK_HALF + QUIET)
                           && (SCLK_HALF >= 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_QUIET} state_t;

    state_t                state;
    logic [PER_W-1:0]      per_cnt;
    logic [PH_W-1:0]       phase;
    logic [BIT_W-1:0]      bit_cnt;
    logic [Q_W-1:0]        q_cnt;
    logic [FRAME_BITS-1:0] shift;
    logic                  tick;

    assign tick = enable && (per_cnt == PER_LAST);
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            per_cnt <= '0;
        end else if (!enable || per_cnt == PER_LAST) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cs_n         <= 1'b1;
            sclk         <= 1'b1;
            phase        <= '0;
            bit_cnt      <= '0;
            q_cnt        <= '0;
            shift        <= '0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            // Ticks landing in a busy frame are dropped, never queued.
            overrun      <= tick && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        state   <= S_CONV;
                        cs_n    <= 1'b0;
                        phase   <= '0;
                        bit_cnt <= '0;
                    end
                end
                S_CONV: begin
                    if (bit_cnt == BIT_LAST) begin
                        state        <= S_QUIET;
                        cs_n         <= 1'b1;
                        q_cnt        <= '0;
                        sample_data  <= shift[DATA_W-1:0];
                        sample_valid <= 1'b1;
                        frame_err    <= |shift[FRAME_BITS-1:DATA_W];
                    end else if (phase == PH_LAST) begin
                        phase <= '0;
                        sclk  <= ~sclk;
                        // Capture on the edge that drives sclk back high.
                        if (!sclk) begin
                            shift   <= {shift[FRAME_BITS-2:0], sdata};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                S_QUIET: begin
                    if (q_cnt == Q_LAST) state <= S_IDLE;
                    else                 q_cnt <= q_cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    generate
        if (CHECK_LEGAL != 0) begin : g_legal
            a_legal: assert property (@(posedge clk) disable iff (!reset) LEGAL);
        end
    endgenerate

endmodule

// File: tb/tb_adc_sample_controller.sv
// Directed bench for adc_sample_controller: reset, frame timing, rate, framing error,
// enable handling, and overrun behaviour on a short-period second instance.
module tb_adc_sample_controller;

    localparam int CLK_DIV = 2268;
    localparam int SH      = 4;

    logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, sdata = 1'b0;
    logic        cs_n, sclk, sample_valid, frame_err, overrun, busy;
    logic [11:0] sample_data;

    logic        enable2 = 1'b0, sdata2 = 1'b0;
    logic        cs_n2, sclk2, sample_valid2, frame_err2, overrun2, busy2;
    logic [11:0] sample_data2;

    adc_sample_controller dut (
        .clk(clk), .reset(reset), .enable(enable), .sdata(sdata),
        .cs_n(cs_n), .sclk(sclk), .sample_data(sample_data), .sample_valid(sample_valid),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    adc_sample_controller #(.CLK_DIV(100), .SCLK_HALF(4), .QUIET(8), .CHECK_LEGAL(0)) dut2 (
        .clk(clk), .reset(reset), .enable(enable2), .sdata(sdata2),
        .cs_n(cs_n2), .sclk(sclk2), .sample_data(sample_data2), .sample_valid(sample_valid2),
        .frame_err(frame_err2), .overrun(overrun2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;

    // ADC model: presents the next frame bit, MSB first, on each sclk fall.
    logic [15:0] adc_word = 16'h0ABC;
    int bidx = 0;
    always @(negedge sclk or posedge cs_n) begin
        if (cs_n) bidx = 0;
        else begin
            if (bidx < 16) sdata = adc_word[15 - bidx];
            bidx = bidx + 1;
        end
    end

    // Event log for the main instance, updated just after each rising edge.
    int cs_falls = 0, cs_fall_cyc = 0, rises = 0, falls = 0;
    int valid_n = 0, valid_cyc = 0, valid_rises = 0, ovr_n = 0;
    int rise_t[32], fall_t[32];
    logic prev_cs = 1'b1, prev_sclk = 1'b1;
    always @(posedge clk) begin
        #1;
        if (prev_cs && !cs_n) begin cs_falls++; cs_fall_cyc = cyc; rises = 0; falls = 0; end
        if (!prev_sclk && sclk && !cs_n && rises < 32) begin rise_t[rises] = cyc; rises++; end
        if (prev_sclk && !sclk && falls < 32) begin fall_t[falls] = cyc; falls++; end
        if (sample_valid) begin valid_n++; valid_cyc = cyc; valid_rises = rises; end
        if (overrun) ovr_n++;
        prev_cs = cs_n; prev_sclk = sclk;
    end

    int cf2 = 0, r2 = 0, v2 = 0, ovr2 = 0, r2_bad = 0, e2 = 0;
    logic prev_cs2 = 1'b1, prev_s2 = 1'b1;
    always @(posedge clk) begin
        #1;
        if (prev_cs2 && !cs_n2) begin cf2++; r2 = 0; end
        if (!prev_s2 && sclk2 && !cs_n2) r2++;
        if (sample_valid2) begin v2++; if (r2 != 16) r2_bad++; if (frame_err2) e2++; end
        if (overrun2) ovr2++;
        prev_cs2 = cs_n2; prev_s2 = sclk2;
    end

    task automatic wait_valid(input int n0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (valid_n > n0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_cs_fall(input int n0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cs_falls > n0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if ({cs_n, sclk, sample_valid, frame_err, overrun, busy} !== 6'b110000) begin
            n_bad++; $display("FAIL reset_outputs: got %b want 110000",
                {cs_n, sclk, sample_valid, frame_err, overrun, busy}); end
        n_cmp++; if (sample_data !== 12'h000) begin
            n_bad++; $display("FAIL reset_data: got %h want 000", sample_data); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || cs_n !== 1'b1) begin
            n_bad++; $display("FAIL reset_idle_no_enable: busy=%b cs_n=%b want 0 1", busy, cs_n); end
    endtask

    task automatic test_nominal();
        int e, n0, bad;
        bit ok;
        adc_word = 16'h0ABC;
        n0 = valid_n;
        @(negedge clk); enable = 1'b1; e = cyc;
        wait_valid(n0, CLK_DIV + 200, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL nominal_valid_seen: got %b want 1", ok); end
        // Cycle 1 is the first enabled cycle, so cs_n low in cycle CLK_DIV+1 is CLK_DIV edges later.
        n_cmp++; if (cs_fall_cyc - e != CLK_DIV) begin
            n_bad++; $display("FAIL first_cs_fall: got %0d want %0d", cs_fall_cyc - e, CLK_DIV); end
        n_cmp++; if (valid_rises != 16) begin
            n_bad++; $display("FAIL nominal_rises: got %0d want 16", valid_rises); end
        bad = (fall_t[0] - cs_fall_cyc != SH) ? 1 : 0;
        for (int k = 0; k < 16; k++) begin
            if (rise_t[k] - fall_t[k] != SH) bad++;
            if (k > 0 && rise_t[k] - rise_t[k-1] != 2 * SH) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL sclk_timing: got %0d bad edges want 0", bad); end
        n_cmp++; if (sample_valid !== 1'b1 || sample_data !== 12'hABC || frame_err !== 1'b0) begin
            n_bad++; $display("FAIL nominal_data: valid=%b data=%h err=%b want 1 abc 0",
                sample_valid, sample_data, frame_err); end
        n_cmp++; if (valid_cyc - cs_fall_cyc != 129) begin
            n_bad++; $display("FAIL latency: got %0d want 129 after cs fall", valid_cyc - cs_fall_cyc); end
        @(negedge clk);
        n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL valid_width: got 1 want 0"); end
        while (cyc < cs_fall_cyc + 136) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_in_quiet: got %b want 1", busy); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_quiet: got %b want 0", busy); end
    endtask

    task automatic test_rate();
        int prev, n0, o0;
        bit ok;
        o0 = ovr_n;
        for (int i = 0; i < 10; i++) begin
            prev = valid_cyc; n0 = valid_n;
            wait_valid(n0, CLK_DIV + 50, ok);
            n_cmp++; if (!ok || valid_cyc - prev != CLK_DIV || valid_rises != 16) begin
                n_bad++; $display("FAIL rate_period_%0d: gap=%0d rises=%0d want %0d 16",
                    i, valid_cyc - prev, valid_rises, CLK_DIV); end
        end
        n_cmp++; if (ovr_n != o0) begin n_bad++; $display("FAIL rate_no_overrun: got %0d want 0", ovr_n - o0); end
    endtask

    task automatic test_framing();
        bit ok;
        adc_word = 16'h1001;
        wait_valid(valid_n, CLK_DIV + 50, ok);
        n_cmp++; if (!ok || sample_data !== 12'h001 || frame_err !== 1'b1) begin
            n_bad++; $display("FAIL framing_err: data=%h err=%b want 001 1", sample_data, frame_err); end
        adc_word = 16'h0ABC;
        wait_valid(valid_n, CLK_DIV + 50, ok);
        n_cmp++; if (!ok || sample_data !== 12'hABC || frame_err !== 1'b0) begin
            n_bad++; $display("FAIL framing_recover: data=%h err=%b want abc 0", sample_data, frame_err); end
    endtask

    task automatic test_enable();
        int n_cs, e;
        bit ok;
        wait_cs_fall(cs_falls, CLK_DIV + 50, ok);
        repeat (20) @(negedge clk);
        enable = 1'b0;
        wait_valid(valid_n, 200, ok);
        n_cmp++; if (!ok || sample_data !== 12'hABC || valid_rises != 16) begin
            n_bad++; $display("FAIL enable_drop_frame: data=%h rises=%0d want abc 16", sample_data, valid_rises); end
        n_cs = cs_falls;
        repeat (3000) @(negedge clk);
        n_cmp++; if (cs_falls != n_cs) begin
            n_bad++; $display("FAIL enable_off_idle: got %0d cs falls want 0", cs_falls - n_cs); end
        enable = 1'b1; e = cyc;
        wait_cs_fall(n_cs, CLK_DIV + 50, ok);
        n_cmp++; if (!ok || cs_fall_cyc - e != CLK_DIV) begin
            n_bad++; $display("FAIL reenable_tick: got %0d want %0d", cs_fall_cyc - e, CLK_DIV); end
    endtask

    task automatic test_reset_mid();
        int e, n_cs;
        bit ok;
        repeat (30) @(negedge clk);
        n_cmp++; if (cs_n !== 1'b0) begin n_bad++; $display("FAIL reset_mid_pre: cs_n=%b want 0", cs_n); end
        reset = 1'b0;
        #1;
        n_cmp++; if ({cs_n, sclk, sample_valid, frame_err, overrun, busy} !== 6'b110000) begin
            n_bad++; $display("FAIL reset_mid_async: got %b want 110000",
                {cs_n, sclk, sample_valid, frame_err, overrun, busy}); end
        n_cmp++; if (sample_data !== 12'h000) begin
            n_bad++; $display("FAIL reset_mid_data: got %h want 000", sample_data); end
        @(negedge clk); reset = 1'b1; e = cyc; n_cs = cs_falls;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || cs_n !== 1'b1) begin
            n_bad++; $display("FAIL reset_release_idle: busy=%b cs_n=%b want 0 1", busy, cs_n); end
        wait_cs_fall(n_cs, CLK_DIV + 50, ok);
        n_cmp++; if (!ok || cs_fall_cyc - e != CLK_DIV) begin
            n_bad++; $display("FAIL reset_period_clear: got %0d want %0d", cs_fall_cyc - e, CLK_DIV); end
        enable = 1'b0;
        wait_valid(valid_n, 200, ok);
    endtask

    task automatic test_overrun();
        bit ok;
        ok = 1'b0;
        @(negedge clk); enable2 = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (v2 >= 4) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok || v2 != 4) begin n_bad++; $display("FAIL ovr_frames: got %0d want 4", v2); end
        // Ticks at 100,300,500,700 after the first land mid-frame; 200,400,600 start frames.
        n_cmp++; if (ovr2 != 4) begin n_bad++; $display("FAIL ovr_count: got %0d want 4", ovr2); end
        n_cmp++; if (cf2 != 4) begin n_bad++; $display("FAIL ovr_no_restart: got %0d cs falls want 4", cf2); end
        n_cmp++; if (r2_bad != 0 || e2 != 0 || sample_data2 !== 12'h000) begin
            n_bad++; $display("FAIL ovr_frame_integrity: bad=%0d err=%0d data=%h want 0 0 000",
                r2_bad, e2, sample_data2); end
        enable2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_rate();
        test_framing();
        test_enable();
        test_reset_mid();
        test_overrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
